// File: rtl/run_controller.sv
// Run sequencer for the single-cycle core: host req/ack handshake, start pulse
// for the program counter, RUN-cycle counting, done-address detection and a
// watchdog that ends a run that never reaches its done address.
module run_controller #(
    parameter int unsigned PC_BITS        = 10,
    parameter int unsigned DONE_ADDR0     = 493,
    parameter int unsigned DONE_ADDR1     = 3,
    parameter int unsigned DONE_ADDR2     = 35,
    parameter int unsigned START_CYCLES   = 2,
    parameter int unsigned TIMEOUT_CYCLES = 50000
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic               req,
    input  logic [1:0]         prog_sel,
    input  logic [PC_BITS-1:0] pc,
    output logic               start,
    output logic               run,
    output logic               ack,
    output logic               timeout,
    output logic [15:0]        cycle_count
);

    localparam logic [PC_BITS-1:0] DoneAddr0   = PC_BITS'(DONE_ADDR0);
    localparam logic [PC_BITS-1:0] DoneAddr1   = PC_BITS'(DONE_ADDR1);
    localparam logic [PC_BITS-1:0] DoneAddr2   = PC_BITS'(DONE_ADDR2);
    // Start counter is loaded with START_CYCLES-1 and leaves START when it reads 0.
    localparam logic [3:0]         StartLast   = 4'(START_CYCLES - 1);
    // Watchdog fires on the edge that takes the count to TIMEOUT_CYCLES.
    localparam logic [15:0]        TimeoutLast = 16'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StRun,
        StDone,
        StFault
    } state_e;

    state_e             state_q;
    logic [3:0]         start_cnt_q;
    logic [PC_BITS-1:0] done_addr_q;
    logic [15:0]        count_q;
    logic               start_q;
    logic               run_q;
    logic               ack_q;
    logic               timeout_q;

    logic [PC_BITS-1:0] sel_addr;
    logic               done_hit;
    logic               timeout_hit;
    logic [15:0]        count_inc;

    // Done address for the requested program; select 3 falls back to program 0.
    always_comb begin
        sel_addr = DoneAddr0;
        case (prog_sel)
            2'd1:    sel_addr = DoneAddr1;
            2'd2:    sel_addr = DoneAddr2;
            default: sel_addr = DoneAddr0;
        endcase
    end

    // Compare terms used only inside RUN; START never consults the done compare.
    always_comb begin
        done_hit    = (pc == done_addr_q);
        timeout_hit = (count_q == TimeoutLast);
        count_inc   = count_q + 16'd1;
    end

    // Run sequencer: state, counters and registered outputs updated together.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q     <= StIdle;
            start_cnt_q <= 4'd0;
            done_addr_q <= DoneAddr0;
            count_q     <= 16'd0;
            start_q     <= 1'b0;
            run_q       <= 1'b0;
            ack_q       <= 1'b0;
            timeout_q   <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (req) begin
                        state_q     <= StStart;
                        done_addr_q <= sel_addr;
                        count_q     <= 16'd0;
                        start_cnt_q <= StartLast;
                        start_q     <= 1'b1;
                    end
                end
                StStart: begin
                    if (!req) begin
                        state_q <= StIdle;
                        start_q <= 1'b0;
                    end else if (start_cnt_q == 4'd0) begin
                        state_q <= StRun;
                        start_q <= 1'b0;
                        run_q   <= 1'b1;
                    end else begin
                        start_cnt_q <= start_cnt_q - 4'd1;
                    end
                end
                StRun: begin
                    // Every RUN edge counts, including the one that leaves RUN.
                    count_q <= count_inc;
                    if (!req) begin
                        state_q <= StIdle;
                        run_q   <= 1'b0;
                    end else if (done_hit) begin
                        state_q <= StDone;
                        run_q   <= 1'b0;
                        ack_q   <= 1'b1;
                    end else if (timeout_hit) begin
                        state_q   <= StFault;
                        run_q     <= 1'b0;
                        ack_q     <= 1'b1;
                        timeout_q <= 1'b1;
                    end
                end
                StDone: begin
                    if (!req) begin
                        state_q <= StIdle;
                        ack_q   <= 1'b0;
                    end
                end
                StFault: begin
                    if (!req) begin
                        state_q   <= StIdle;
                        ack_q     <= 1'b0;
                        timeout_q <= 1'b0;
                    end
                end
                default: begin
                    state_q   <= StIdle;
                    start_q   <= 1'b0;
                    run_q     <= 1'b0;
                    ack_q     <= 1'b0;
                    timeout_q <= 1'b0;
                end
            endcase
        end
    end

    assign start       = start_q;
    assign run         = run_q;
    assign ack         = ack_q;
    assign timeout     = timeout_q;
    assign cycle_count = count_q;

endmodule

// File: tb/tb_run_controller.sv
// Bench for run_controller: two instances (default parameters, and a short
// watchdog with program 1 ending at address 0) share one input stream.
// Directed steps cover the scenarios of interest, then a randomized stretch;
// every cycle both instances are compared with a behavioural model.
module tb_run_controller;

    localparam int SC_A = 2;
    localparam int TO_A = 50000;
    localparam int SC_B = 3;
    localparam int TO_B = 10;

    localparam int P_IDLE  = 0;
    localparam int P_START = 1;
    localparam int P_RUN   = 2;
    localparam int P_DONE  = 3;
    localparam int P_FAULT = 4;

    logic       clock = 1'b0;
    logic       reset_n = 1'b0;
    logic       req = 1'b0;
    logic [1:0] prog_sel = 2'd0;
    logic [9:0] pc = 10'd0;

    logic        start_a, run_a, ack_a, timeout_a;
    logic [15:0] count_a;
    logic        start_b, run_b, ack_b, timeout_b;
    logic [15:0] count_b;

    int n_cmp = 0;
    int n_fail = 0;

    // Behavioural model: phase, remaining start cycles, RUN count, done address.
    int m_phase[2];
    int m_left[2];
    int m_count[2];
    int m_addr[2];
    int sc_of[2] = '{SC_A, SC_B};
    int to_of[2] = '{TO_A, TO_B};
    int addr_of[2][4] = '{'{493, 3, 35, 493}, '{493, 0, 35, 493}};

    run_controller #(
        .PC_BITS(10), .DONE_ADDR0(493), .DONE_ADDR1(3), .DONE_ADDR2(35),
        .START_CYCLES(SC_A), .TIMEOUT_CYCLES(TO_A)
    ) dut_a (
        .clock(clock), .reset_n(reset_n), .req(req), .prog_sel(prog_sel), .pc(pc),
        .start(start_a), .run(run_a), .ack(ack_a), .timeout(timeout_a),
        .cycle_count(count_a)
    );

    run_controller #(
        .PC_BITS(10), .DONE_ADDR0(493), .DONE_ADDR1(0), .DONE_ADDR2(35),
        .START_CYCLES(SC_B), .TIMEOUT_CYCLES(TO_B)
    ) dut_b (
        .clock(clock), .reset_n(reset_n), .req(req), .prog_sel(prog_sel), .pc(pc),
        .start(start_b), .run(run_b), .ack(ack_b), .timeout(timeout_b),
        .cycle_count(count_b)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_step(input int i);
        if (!reset_n) begin
            m_phase[i] = P_IDLE;
            m_count[i] = 0;
        end else begin
            case (m_phase[i])
                P_IDLE: if (req) begin
                    m_addr[i]  = addr_of[i][prog_sel];
                    m_count[i] = 0;
                    m_left[i]  = sc_of[i];
                    m_phase[i] = P_START;
                end
                P_START: begin
                    if (!req) m_phase[i] = P_IDLE;
                    else begin
                        m_left[i]--;
                        if (m_left[i] == 0) m_phase[i] = P_RUN;
                    end
                end
                P_RUN: begin
                    m_count[i]++;
                    if (!req) m_phase[i] = P_IDLE;
                    else if (int'(pc) == m_addr[i]) m_phase[i] = P_DONE;
                    else if (m_count[i] == to_of[i]) m_phase[i] = P_FAULT;
                end
                default: if (!req) m_phase[i] = P_IDLE;
            endcase
        end
    endtask

    task automatic check_model;
        chk("a.start",   start_a,   m_phase[0] == P_START);
        chk("a.run",     run_a,     m_phase[0] == P_RUN);
        chk("a.ack",     ack_a,     m_phase[0] == P_DONE || m_phase[0] == P_FAULT);
        chk("a.timeout", timeout_a, m_phase[0] == P_FAULT);
        chk("a.count",   count_a,   m_count[0]);
        chk("b.start",   start_b,   m_phase[1] == P_START);
        chk("b.run",     run_b,     m_phase[1] == P_RUN);
        chk("b.ack",     ack_b,     m_phase[1] == P_DONE || m_phase[1] == P_FAULT);
        chk("b.timeout", timeout_b, m_phase[1] == P_FAULT);
        chk("b.count",   count_b,   m_count[1]);
    endtask

    // One clock: inputs already set, model follows the edge, compare 1 ns later.
    task automatic tick;
        @(posedge clock);
        model_step(0);
        model_step(1);
        #1;
        check_model();
    endtask

    task automatic ticks(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    initial begin
        for (int i = 0; i < 2; i++) begin
            m_phase[i] = P_IDLE;
            m_left[i]  = 0;
            m_count[i] = 0;
            m_addr[i]  = 493;
        end

        // Reset held with req high: everything quiet.
        reset_n = 1'b0; req = 1'b1; prog_sel = 2'd1; pc = 10'd0;
        ticks(3);
        chk("rst.start", start_a, 1'b0);
        chk("rst.run", run_a, 1'b0);
        chk("rst.ack", ack_a, 1'b0);
        chk("rst.timeout", timeout_a, 1'b0);
        chk("rst.count", count_a, 16'd0);
        chk("rst.b_count", count_b, 16'd0);

        // First edge after release enters START.
        reset_n = 1'b1;
        tick();
        chk("rel.a_start", start_a, 1'b1);
        chk("rel.b_start", start_b, 1'b1);
        tick();
        chk("st2.a_start", start_a, 1'b1);
        tick();
        chk("st3.a_start", start_a, 1'b0);
        chk("st3.a_run", run_a, 1'b1);

        // Program 1 on A: pc 0,1,2,3 -> done with count 4.
        for (int p = 0; p < 4; p++) begin
            pc = 10'(p);
            tick();
        end
        chk("p1.ack", ack_a, 1'b1);
        chk("p1.count", count_a, 16'd4);
        chk("p1.run", run_a, 1'b0);
        pc = 10'd0;
        ticks(2);
        chk("p1.hold_ack", ack_a, 1'b1);
        chk("p1.no_restart", start_a, 1'b0);
        chk("p1.hold_count", count_a, 16'd4);
        req = 1'b0;
        tick();
        chk("p1.ack_drop", ack_a, 1'b0);

        // B with done address 0 and pc=0 through START: no early match.
        req = 1'b1; prog_sel = 2'd1; pc = 10'd0;
        ticks(4);
        chk("z.b_run", run_b, 1'b1);
        chk("z.b_noack", ack_b, 1'b0);
        tick();
        chk("z.b_ack", ack_b, 1'b1);
        chk("z.b_count", count_b, 16'd1);
        req = 1'b0;
        tick();
        chk("z.a_abort_ack", ack_a, 1'b0);

        // Watchdog on B: no match -> fault with count 10.
        req = 1'b1; prog_sel = 2'd2; pc = 10'd100;
        ticks(13);
        chk("to.b_run", run_b, 1'b1);
        chk("to.b_count9", count_b, 16'd9);
        tick();
        chk("to.b_ack", ack_b, 1'b1);
        chk("to.b_timeout", timeout_b, 1'b1);
        chk("to.b_count", count_b, 16'd10);
        tick();
        chk("to.b_frozen", count_b, 16'd10);
        req = 1'b0;
        tick();
        chk("to.b_timeout_drop", timeout_b, 1'b0);
        chk("to.b_ack_drop", ack_b, 1'b0);

        // Match in the watchdog cycle wins.
        req = 1'b1; prog_sel = 2'd2; pc = 10'd100;
        ticks(13);
        pc = 10'd35;
        tick();
        chk("tm.b_ack", ack_b, 1'b1);
        chk("tm.b_timeout", timeout_b, 1'b0);
        chk("tm.b_count", count_b, 16'd10);
        req = 1'b0;
        tick();

        // Abort A in RUN cycle 5.
        req = 1'b1; prog_sel = 2'd0; pc = 10'd7;
        ticks(7);
        chk("ab.a_run", run_a, 1'b1);
        chk("ab.a_count4", count_a, 16'd4);
        req = 1'b0;
        tick();
        chk("ab.a_run_off", run_a, 1'b0);
        chk("ab.a_noack", ack_a, 1'b0);
        chk("ab.a_count", count_a, 16'd5);

        // Select 3 uses address 493; changing select mid-run has no effect.
        req = 1'b1; prog_sel = 2'd3; pc = 10'd100;
        tick();
        chk("s3.a_start", start_a, 1'b1);
        chk("s3.a_cleared", count_a, 16'd0);
        ticks(2);
        prog_sel = 2'd1; pc = 10'd3;
        ticks(2);
        chk("s3.a_run", run_a, 1'b1);
        chk("s3.a_noack", ack_a, 1'b0);
        pc = 10'd493;
        tick();
        chk("s3.a_ack", ack_a, 1'b1);
        chk("s3.a_count", count_a, 16'd3);
        req = 1'b0;
        tick();

        // Randomized stretch against the model.
        for (int n = 0; n < 1500; n++) begin
            int k;
            reset_n = ($urandom_range(0, 99) >= 2);
            if ($urandom_range(0, 9) == 0) req = ~req;
            prog_sel = 2'($urandom_range(0, 3));
            k = $urandom_range(0, 9);
            case (k)
                0: pc = 10'd0;
                1: pc = 10'd3;
                2: pc = 10'd35;
                3: pc = 10'd493;
                default: pc = 10'($urandom_range(0, 1023));
            endcase
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
